// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and constants for the note sequencer
package music_pkg;

  typedef logic [6:0] pitch_t;
  typedef logic [4:0] octave_t;

  localparam pitch_t PITCH_REST     = 7'd15;
  localparam int     CLK_HZ_DEFAULT = 27000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_DONE
  } seq_state_e;

  // Only 0..11 name real semitones; every other code is silent.
  function automatic logic is_rest(input pitch_t p);
    return p > 7'd11;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with clear and enable, 1-cycle tick on wrap
module ms_tick_gen #(
  parameter int PERIOD = 27000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = i_en && w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - walks a song table, holding each note for its duration in ms
// Optional feature macro: SEQ_LOOP_EN (end of song restarts at note 0 instead of stopping).
module note_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int ADDR_W = 10,
  parameter int DUR_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] note_id,
  input  pitch_t            rom_pitch,
  input  logic [DUR_W-1:0]  rom_dur_ms,
  input  octave_t           rom_octave,
  output pitch_t            pitch,
  output octave_t           octave,
  output logic              sounding,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam logic [ADDR_W-1:0] LAST_ID = '1;

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_note_id;
  pitch_t            r_pitch;
  octave_t           r_octave;
  logic [DUR_W-1:0]  r_ms_cnt;
  logic              r_sounding;
  logic              r_strobe;
  logic              r_busy;
  logic              r_done;

  logic w_tick;
  logic w_clear;
  logic w_en;

  // Prescaler restarts from zero at the beginning of every note.
  assign w_clear = (r_state != ST_PLAY);
  assign w_en    = (r_state == ST_PLAY) && !pause;

  ms_tick_gen #(
    .PERIOD (TICK_DIV)
  ) u_tick (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (w_clear),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_note_id  <= '0;
      r_pitch    <= '0;
      r_octave   <= '0;
      r_ms_cnt   <= '0;
      r_sounding <= 1'b0;
      r_strobe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_sounding <= 1'b0;
          if (start) begin
            r_state   <= ST_FETCH;
            r_note_id <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (rom_dur_ms == '0) begin
            // A looping table whose first entry is the marker would spin forever; stop instead.
            if (LOOP_EN && (r_note_id != '0)) begin
              r_note_id <= '0;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_state    <= ST_PLAY;
            r_pitch    <= rom_pitch;
            r_octave   <= rom_octave;
            r_ms_cnt   <= rom_dur_ms;
            r_strobe   <= 1'b1;
            r_sounding <= !is_rest(rom_pitch) && !pause;
          end
        end

        ST_PLAY: begin
          r_sounding <= !is_rest(r_pitch) && !pause;
          if (w_tick) begin
            if (r_ms_cnt == DUR_W'(1)) begin
              r_sounding <= 1'b0;
              if (r_note_id != LAST_ID) begin
                r_note_id <= r_note_id + ADDR_W'(1);
                r_state   <= ST_FETCH;
              end else if (LOOP_EN) begin
                r_note_id <= '0;
                r_state   <= ST_FETCH;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_ms_cnt <= r_ms_cnt - DUR_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign note_id     = r_note_id;
  assign pitch       = r_pitch;
  assign octave      = r_octave;
  assign sounding    = r_sounding;
  assign note_strobe = r_strobe;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with a 4-entry behavioural song table
module tb_note_sequencer;
  import music_pkg::*;

  localparam int CLK_HZ = 4000;
  localparam int ADDR_W = 2;
  localparam int DUR_W  = 15;
  localparam int P      = CLK_HZ / 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [ADDR_W-1:0] note_id;
  pitch_t            rom_pitch, pitch;
  logic [DUR_W-1:0]  rom_dur_ms;
  octave_t           rom_octave, octave;
  logic sounding, note_strobe, busy, done;

  pitch_t           t_pitch [4];
  logic [DUR_W-1:0] t_dur   [4];
  octave_t          t_oct   [4];

  always_comb begin
    rom_pitch  = t_pitch[note_id];
    rom_dur_ms = t_dur[note_id];
    rom_octave = t_oct[note_id];
  end

  always #5 clk = ~clk;

  note_sequencer #(.CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .note_id(note_id),
    .rom_pitch(rom_pitch), .rom_dur_ms(rom_dur_ms), .rom_octave(rom_octave),
    .pitch(pitch), .octave(octave), .sounding(sounding), .note_strobe(note_strobe),
    .busy(busy), .done(done)
  );

  typedef struct {
    int pitch;
    int octave;
    int id;
    int len;
    int snd;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // len: cycles from this note's strobe to the next strobe or done rising; snd: sounding cycles.
  task automatic push(input int p, input int o, input int id, input int len, input int snd);
    exp_t e;
    e.pitch = p; e.octave = o; e.id = id; e.len = len; e.snd = snd;
    sb.push_back(e);
  endtask

  task automatic set_tbl(input int i, input int p, input int d, input int o);
    t_pitch[i] = pitch_t'(p);
    t_dur[i]   = DUR_W'(d);
    t_oct[i]   = octave_t'(o);
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 4; i++) set_tbl(i, 0, 0, 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_id"}, int'(note_id), 0);
    check({tag, "_pitch"}, int'(pitch), 0);
    check({tag, "_oct"}, int'(octave), 0);
    check({tag, "_snd"}, int'(sounding), 0);
    check({tag, "_strb"}, int'(note_strobe), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: pops an expectation on every strobe and measures each note's length.
  exp_t cur;
  int   cyc = 0, t0 = 0, snd_cnt = 0;
  bit   meas = 1'b0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      meas = 1'b0;
    end else begin
      if (meas && (note_strobe || (done && !done_q))) begin
        check("note_len", cyc - t0, cur.len);
        check("snd_cycles", snd_cnt, cur.snd);
        meas = 1'b0;
      end
      if (note_strobe) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("strb_pitch", int'(pitch), cur.pitch);
          check("strb_oct", int'(octave), cur.octave);
          check("strb_id", int'(note_id), cur.id);
          t0 = cyc;
          snd_cnt = 0;
          meas = 1'b1;
        end
      end
      if (meas) snd_cnt += int'(sounding);
    end
    done_q = done;
  end

  initial begin
    clear_tbl();
    cycles(2);
    check_zero("rst0");
    rst = 1'b0;
    cycles(2);

    // Two notes then end marker.
    set_tbl(0, 0, 3, 4); set_tbl(1, 1, 2, 4);
    push(0, 4, 0, 3 * P + 1, 3 * P);
    push(1, 4, 1, 2 * P + 1, 2 * P);
    pulse_start();
    wait_done("t1_done", 200);
    check("t1_id", int'(note_id), 2);
    check("t1_snd", int'(sounding), 0);
    check("t1_pitch", int'(pitch), 1);
    check("t1_busy", int'(busy), 0);
    check("t1_sb", sb.size(), 0);

    // Rest entry.
    clear_tbl();
    set_tbl(0, int'(PITCH_REST), 2, 3);
    push(int'(PITCH_REST), 3, 0, 2 * P + 1, 0);
    pulse_start();
    cycles(3);
    check("t2_busy", int'(busy), 1);
    wait_done("t2_done", 200);
    check("t2_sb", sb.size(), 0);

    // Pause for five cycles mid-note.
    clear_tbl();
    set_tbl(0, 7, 3, 2);
    push(7, 2, 0, 3 * P + 1 + 5, 3 * P);
    pulse_start();
    cycles(3);
    pause = 1'b1;
    cycles(2);
    check("t3_paused_snd", int'(sounding), 0);
    check("t3_paused_pitch", int'(pitch), 7);
    cycles(3);
    pause = 1'b0;
    wait_done("t3_done", 200);
    check("t3_sb", sb.size(), 0);

    // Reset during the second note, then restart.
    clear_tbl();
    set_tbl(0, 2, 1, 1); set_tbl(1, 5, 3, 6);
    push(2, 1, 0, P + 1, P);
    push(5, 6, 1, 0, 0);
    pulse_start();
    cycles(P + 4);
    check("t4_mid_id", int'(note_id), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t4_rst");
    rst = 1'b0;
    sb.delete();
    push(2, 1, 0, P + 1, P);
    push(5, 6, 1, 3 * P + 1, 3 * P);
    pulse_start();
    wait_done("t4_done", 200);
    check("t4_sb", sb.size(), 0);

    // All four entries 1 ms: runs off the end of the table.
    for (int i = 0; i < 4; i++) set_tbl(i, i + 2, 1, i + 1);
`ifdef SEQ_LOOP_EN
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(i + 2, i + 1, i, P + 1, P);
    pulse_start();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("t5_loop_sb", sb.size(), 0);
    check("t5_loop_done", int'(done), 0);
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    for (int i = 0; i < 3; i++) push(i + 2, i + 1, i, P + 1, P);
    push(5, 4, 3, P, P);
    pulse_start();
    wait_done("t5_done", 200);
    check("t5_id", int'(note_id), 3);
    check("t5_sb", sb.size(), 0);
`endif

    // start held high while playing must not restart the song.
    clear_tbl();
    set_tbl(0, 0, 2, 1);
    push(0, 1, 0, 2 * P + 1, 2 * P);
    start = 1'b1;
    cycles(6);
    check("t6_busy", int'(busy), 1);
    start = 1'b0;
    wait_done("t6_done", 200);
    check("t6_id", int'(note_id), 1);
    check("t6_sb", sb.size(), 0);

    // Entry 0 is the end marker: one FETCH cycle then DONE, no strobe.
    clear_tbl();
    pulse_start();
    check("t6b_fetch_busy", int'(busy), 1);
    check("t6b_fetch_done", int'(done), 0);
    @(negedge clk);
    check("t6b_done", int'(done), 1);
    check("t6b_busy", int'(busy), 0);
    check("t6b_id", int'(note_id), 0);
    cycles(3);
    check("t6b_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
